layer_compositor: RTL and testbench

- Parametrised pixel compositor for the fencing game display path. It replaces the fixed two-player sprite mux with NUM_LAYERS generic rectangular layers, ordered by a fixed priority.
- Layer geometry is double-buffered per frame to prevent tearing.
- An on-board screen-mode FSM (START/PLAY/WIN/LOSE) is driven by IR codes and health values, and a frame-counted hit-flash effect is included.
- Sits between the game-logic/sprite sources and the HDMI/TMDS encoder; pixel_out is fixed-latency relative to hcount_in/vcount_in.

---
 rtl/fence_display_pkg.sv | 18 +
 rtl/layer_hit_unit.sv | 59 +++++
 rtl/layer_compositor.sv | 192 +++++++++++++++++++
 tb/tb_layer_compositor.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/fence_display_pkg.sv
// Shared types and constants for the fencing-game display path.
//   mode_e  : screen mode encoding (START/PLAY/WIN/LOSE)
//   rgb_t   : 24-bit RGB pixel, {R,G,B}
package fence_display_pkg;

   typedef enum logic [1:0] {
      MODE_START = 2'd0,
      MODE_PLAY  = 2'd1,
      MODE_WIN   = 2'd2,
      MODE_LOSE  = 2'd3
   } mode_e;

   typedef logic [23:0] rgb_t;

   localparam rgb_t COLOR_WHITE = 24'hFF_FF_FF;
   localparam rgb_t COLOR_BLACK = 24'h00_00_00;

endpackage

// File: rtl/layer_hit_unit.sv
// One rectangular layer: frame-latched shadow geometry plus a combinational
// point-in-rectangle test against the current pixel.
//   clk_in, rst_n_in          : pixel clock, async active-low reset
//   nf_in                     : new-frame pulse, latches the shadow copy
//   en_in/x_in/y_in/xmax_in/ymax_in/color_in : live layer description
//   h_in, v_in                : current pixel, zero-extended to 12 bits
//   hit_out                   : pixel lies inside the shadowed rectangle
//   color_out                 : shadowed layer colour
module layer_hit_unit
   import fence_display_pkg::*;
(
   input  logic        clk_in,
   input  logic        rst_n_in,
   input  logic        nf_in,
   input  logic        en_in,
   input  logic [11:0] x_in,
   input  logic [10:0] y_in,
   input  logic [11:0] xmax_in,
   input  logic [10:0] ymax_in,
   input  rgb_t        color_in,
   input  logic [11:0] h_in,
   input  logic [11:0] v_in,
   output logic        hit_out,
   output rgb_t        color_out
);

   logic        en_q;
   logic [11:0] x_q;
   logic [10:0] y_q;
   logic [11:0] xmax_q;
   logic [10:0] ymax_q;
   rgb_t        color_q;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         en_q    <= 1'b0;
         x_q     <= '0;
         y_q     <= '0;
         xmax_q  <= '0;
         ymax_q  <= '0;
         color_q <= COLOR_BLACK;
      end else if (nf_in) begin
         en_q    <= en_in;
         x_q     <= x_in;
         y_q     <= y_in;
         xmax_q  <= xmax_in;
         ymax_q  <= ymax_in;
         color_q <= color_in;
      end
   end

   // Max bounds are exclusive, so a degenerate rectangle can never match.
   assign hit_out = en_q
                 && (h_in >= x_q) && (h_in < xmax_q)
                 && (v_in >= {1'b0, y_q}) && (v_in < {1'b0, ymax_q});

   assign color_out = color_q;

endmodule

// File: rtl/layer_compositor.sv
// Pixel compositor: NUM_LAYERS priority-ordered rectangles over an arena
// border, hit flash and camera background, with a START/PLAY/WIN/LOSE
// screen-mode FSM. pixel_out lags hcount_in/vcount_in by exactly 2 cycles.
//   clk_in, rst_n_in                 : pixel clock, async active-low reset
//   hcount_in, vcount_in, nf_in      : raster position and new-frame pulse
//   ir_in, ir_valid_in               : decoded IR command
//   camera_en_in, camera_pixel_in    : optional camera background
//   start_pixel_in                   : start-screen image
//   layer_*_in                       : packed per-layer geometry/colour
//   player_health_in, opponent_health_in, hit_in : game state
//   mode_out, pixel_out              : screen mode and composited pixel
//
// state      | meaning
// MODE_START | start image shown, waiting for a start IR code
// MODE_PLAY  | layers/border/flash/camera composited, health watched at nf
// MODE_WIN   | full-screen WIN_COLOR, waiting for restart IR code
// MODE_LOSE  | full-screen LOSE_COLOR, waiting for restart IR code
module layer_compositor
   import fence_display_pkg::*;
#(
   parameter int          NUM_LAYERS   = 4,
   parameter int          HEALTH_W     = 3,
   parameter int          FLASH_FRAMES = 8,
   parameter logic [31:0] START_CODE_A = 32'h20DF_5BA4,
   parameter logic [31:0] START_CODE_B = 32'h20DF_5AA5,
   parameter logic [31:0] RESTART_CODE = 32'h20DF_10EF,
   parameter int          BORDER_X     = 960,
   parameter int          BORDER_Y     = 640,
   parameter logic [23:0] FLASH_COLOR  = 24'hFF_00_00,
   parameter logic [23:0] WIN_COLOR    = 24'h00_FF_00,
   parameter logic [23:0] LOSE_COLOR   = 24'hFF_00_00
)(
   input  logic                     clk_in,
   input  logic                     rst_n_in,
   input  logic [10:0]              hcount_in,
   input  logic [9:0]               vcount_in,
   input  logic                     nf_in,
   input  logic [31:0]              ir_in,
   input  logic                     ir_valid_in,
   input  logic                     camera_en_in,
   input  logic [23:0]              camera_pixel_in,
   input  logic [23:0]              start_pixel_in,
   input  logic [NUM_LAYERS-1:0]    layer_en_in,
   input  logic [NUM_LAYERS*12-1:0] layer_x_in,
   input  logic [NUM_LAYERS*11-1:0] layer_y_in,
   input  logic [NUM_LAYERS*12-1:0] layer_xmax_in,
   input  logic [NUM_LAYERS*11-1:0] layer_ymax_in,
   input  logic [NUM_LAYERS*24-1:0] layer_color_in,
   input  logic [HEALTH_W-1:0]      player_health_in,
   input  logic [HEALTH_W-1:0]      opponent_health_in,
   input  logic                     hit_in,
   output logic [1:0]               mode_out,
   output logic [23:0]              pixel_out
);

   localparam int          FW = $clog2(FLASH_FRAMES + 1);
   localparam logic [11:0] BX = 12'(BORDER_X);
   localparam logic [11:0] BY = 12'(BORDER_Y);

   logic [11:0]           h_ext, v_ext;
   logic [NUM_LAYERS-1:0] hit_comb;
   rgb_t                  layer_color [NUM_LAYERS];

   assign h_ext = {1'b0, hcount_in};
   assign v_ext = {2'b0, vcount_in};

   for (genvar i = 0; i < NUM_LAYERS; i++) begin : g_layer
      layer_hit_unit u_hit (
         .clk_in    (clk_in),
         .rst_n_in  (rst_n_in),
         .nf_in     (nf_in),
         .en_in     (layer_en_in[i]),
         .x_in      (layer_x_in[i*12 +: 12]),
         .y_in      (layer_y_in[i*11 +: 11]),
         .xmax_in   (layer_xmax_in[i*12 +: 12]),
         .ymax_in   (layer_ymax_in[i*11 +: 11]),
         .color_in  (layer_color_in[i*24 +: 24]),
         .h_in      (h_ext),
         .v_in      (v_ext),
         .hit_out   (hit_comb[i]),
         .color_out (layer_color[i])
      );
   end

   // Health shadows; the FSM looks at the value the shadow holds after this
   // cycle, so a frame boundary reacts to the freshly captured health.
   logic [HEALTH_W-1:0] player_sh, opp_sh, player_cap, opp_cap;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         player_sh <= '0;
         opp_sh    <= '0;
      end else if (nf_in) begin
         player_sh <= player_health_in;
         opp_sh    <= opponent_health_in;
      end
   end

   assign player_cap = nf_in ? player_health_in   : player_sh;
   assign opp_cap    = nf_in ? opponent_health_in : opp_sh;

   mode_e mode_q, mode_d;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) mode_q <= MODE_START;
      else           mode_q <= mode_d;
   end

   always_comb begin
      mode_d = mode_q;
      case (mode_q)
         MODE_START:
            if (ir_valid_in && (ir_in == START_CODE_A || ir_in == START_CODE_B))
               mode_d = MODE_PLAY;
         MODE_PLAY:
            if (nf_in) begin
               if (player_cap == '0)   mode_d = MODE_LOSE;
               else if (opp_cap == '0) mode_d = MODE_WIN;
            end
         MODE_WIN, MODE_LOSE:
            if (ir_valid_in && ir_in == RESTART_CODE)
               mode_d = MODE_START;
         default: mode_d = MODE_START;
      endcase
   end

   assign mode_out = mode_q;

   logic [FW-1:0] flash_cnt;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in)
         flash_cnt <= '0;
      else if (mode_q == MODE_PLAY && mode_d != MODE_PLAY)
         flash_cnt <= '0;
      else if (mode_q == MODE_PLAY && hit_in)
         flash_cnt <= FW'(FLASH_FRAMES);
      else if (nf_in && flash_cnt != '0)
         flash_cnt <= flash_cnt - 1'b1;
   end

   logic [NUM_LAYERS-1:0] hit_s1;
   logic                  border_s1, cam_en_s1, valid_s1;
   rgb_t                  cam_s1, start_s1;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         hit_s1    <= '0;
         border_s1 <= 1'b0;
         cam_en_s1 <= 1'b0;
         cam_s1    <= COLOR_BLACK;
         start_s1  <= COLOR_BLACK;
         valid_s1  <= 1'b0;
      end else begin
         hit_s1    <= hit_comb;
         border_s1 <= (h_ext == BX && v_ext <= BY) || (v_ext == BY && h_ext <= BX);
         cam_en_s1 <= camera_en_in;
         cam_s1    <= camera_pixel_in;
         start_s1  <= start_pixel_in;
         valid_s1  <= 1'b1;
      end
   end

   rgb_t layer_pix, play_pix, sel_pix;

   always_comb begin
      layer_pix = COLOR_BLACK;
      // Walk from the lowest priority up so the lowest index wins.
      for (int i = NUM_LAYERS - 1; i >= 0; i--)
         if (hit_s1[i]) layer_pix = layer_color[i];

      if (|hit_s1)            play_pix = layer_pix;
      else if (border_s1)     play_pix = COLOR_WHITE;
      else if (flash_cnt != 0) play_pix = FLASH_COLOR;
      else if (cam_en_s1)     play_pix = cam_s1;
      else                    play_pix = COLOR_BLACK;

      case (mode_q)
         MODE_START: sel_pix = start_s1;
         MODE_PLAY:  sel_pix = play_pix;
         MODE_WIN:   sel_pix = WIN_COLOR;
         MODE_LOSE:  sel_pix = LOSE_COLOR;
         default:    sel_pix = COLOR_BLACK;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) pixel_out <= COLOR_BLACK;
      else           pixel_out <= valid_s1 ? sel_pix : COLOR_BLACK;
   end

endmodule

// File: tb/tb_layer_compositor.sv
module tb_layer_compositor;

   logic        clk_in = 1'b0;
   logic        rst_n_in = 1'b0;
   logic [10:0] hcount_in = '0;
   logic [9:0]  vcount_in = '0;
   logic        nf_in = 1'b0;
   logic [31:0] ir_in = '0;
   logic        ir_valid_in = 1'b0;
   logic        camera_en_in = 1'b0;
   logic [23:0] camera_pixel_in = '0;
   logic [23:0] start_pixel_in = '0;
   logic [3:0]  layer_en_in = '0;
   logic [47:0] layer_x_in, layer_xmax_in;
   logic [43:0] layer_y_in, layer_ymax_in;
   logic [95:0] layer_color_in;
   logic [2:0]  player_health_in = 3'd3;
   logic [2:0]  opponent_health_in = 3'd3;
   logic        hit_in = 1'b0;
   logic [1:0]  mode_out;
   logic [23:0] pixel_out;

   int n_cmp = 0;
   int n_bad = 0;

   layer_compositor dut (
      .clk_in            (clk_in),
      .rst_n_in          (rst_n_in),
      .hcount_in         (hcount_in),
      .vcount_in         (vcount_in),
      .nf_in             (nf_in),
      .ir_in             (ir_in),
      .ir_valid_in       (ir_valid_in),
      .camera_en_in      (camera_en_in),
      .camera_pixel_in   (camera_pixel_in),
      .start_pixel_in    (start_pixel_in),
      .layer_en_in       (layer_en_in),
      .layer_x_in        (layer_x_in),
      .layer_y_in        (layer_y_in),
      .layer_xmax_in     (layer_xmax_in),
      .layer_ymax_in     (layer_ymax_in),
      .layer_color_in    (layer_color_in),
      .player_health_in  (player_health_in),
      .opponent_health_in(opponent_health_in),
      .hit_in            (hit_in),
      .mode_out          (mode_out),
      .pixel_out         (pixel_out)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      logic [10:0] h;
      logic [9:0]  v;
      logic [3:0]  en;
      logic        cam_en;
      logic [23:0] cam;
      logic [23:0] exp_pix;
   } vec_t;

   vec_t vecs [13];

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic pulse_nf();
      nf_in = 1'b1;
      tick();
      nf_in = 1'b0;
   endtask

   task automatic send_ir(input logic [31:0] code);
      ir_in = code;
      ir_valid_in = 1'b1;
      tick();
      ir_valid_in = 1'b0;
   endtask

   task automatic set_pos(input logic [10:0] h, input logic [9:0] v);
      hcount_in = h;
      vcount_in = v;
   endtask

   initial begin
      // L0 (100,100)-(200,200) blue, L1 (50,50)-(300,300) red,
      // L2 empty (x==xmax==50), L3 (900,250)-(1000,350) green over border.
      layer_x_in     = {12'd900, 12'd50,   12'd50,  12'd100};
      layer_xmax_in  = {12'd1000, 12'd50,  12'd300, 12'd200};
      layer_y_in     = {11'd250, 11'd0,    11'd50,  11'd100};
      layer_ymax_in  = {11'd350, 11'd1000, 11'd300, 11'd200};
      layer_color_in = {24'h00AA00, 24'h123456, 24'hFF0000, 24'h0000FF};

      vecs[0]  = '{11'd100, 10'd100, 4'b1111, 1'b0, 24'h0, 24'h0000FF};
      vecs[1]  = '{11'd100, 10'd100, 4'b1110, 1'b0, 24'h0, 24'hFF0000};
      vecs[2]  = '{11'd200, 10'd200, 4'b1111, 1'b0, 24'h0, 24'hFF0000};
      vecs[3]  = '{11'd199, 10'd199, 4'b0001, 1'b0, 24'h0, 24'h0000FF};
      vecs[4]  = '{11'd300, 10'd300, 4'b0010, 1'b0, 24'h0, 24'h000000};
      vecs[5]  = '{11'd50,  10'd500, 4'b0100, 1'b0, 24'h0, 24'h000000};
      vecs[6]  = '{11'd960, 10'd300, 4'b0000, 1'b0, 24'h0, 24'hFFFFFF};
      vecs[7]  = '{11'd961, 10'd300, 4'b0000, 1'b0, 24'h0, 24'h000000};
      vecs[8]  = '{11'd960, 10'd300, 4'b1000, 1'b0, 24'h0, 24'h00AA00};
      vecs[9]  = '{11'd960, 10'd640, 4'b0000, 1'b0, 24'h0, 24'hFFFFFF};
      vecs[10] = '{11'd960, 10'd641, 4'b0000, 1'b1, 24'hABCDEF, 24'hABCDEF};
      vecs[11] = '{11'd0,   10'd640, 4'b0000, 1'b0, 24'h0, 24'hFFFFFF};
      vecs[12] = '{11'd500, 10'd500, 4'b0000, 1'b1, 24'h135790, 24'h135790};

      // Reset state
      start_pixel_in = 24'h5A5A5A;
      set_pos(11'd100, 10'd100);
      tick(); tick();
      check("reset_pixel", {8'h0, pixel_out}, 32'h0);
      check("reset_mode", {30'h0, mode_out}, 32'd0);

      rst_n_in = 1'b1;
      tick(); tick(); tick();
      check("start_mode", {30'h0, mode_out}, 32'd0);
      check("start_pixel", {8'h0, pixel_out}, 32'h5A5A5A);

      // Start image follows start_pixel_in with 2-cycle latency
      start_pixel_in = 24'h112233;
      tick();
      check("start_lat1", {8'h0, pixel_out}, 32'h5A5A5A);
      tick();
      check("start_lat2", {8'h0, pixel_out}, 32'h112233);

      send_ir(32'h1234_5678);
      check("ir_ignored", {30'h0, mode_out}, 32'd0);
      send_ir(32'h20DF_5BA4);
      check("enter_play", {30'h0, mode_out}, 32'd1);

      // Shadow registers hold until next frame
      layer_en_in = 4'b1111;
      pulse_nf();
      tick(); tick();
      check("l0_over_l1", {8'h0, pixel_out}, 32'h0000FF);
      layer_en_in = 4'b1110;
      tick(); tick(); tick();
      check("shadow_hold", {8'h0, pixel_out}, 32'h0000FF);
      pulse_nf();
      tick(); tick();
      check("shadow_update", {8'h0, pixel_out}, 32'hFF0000);

      // IR ignored in PLAY
      send_ir(32'h20DF_10EF);
      check("ir_in_play", {30'h0, mode_out}, 32'd1);

      for (int i = 0; i < 13; i++) begin
         layer_en_in     = vecs[i].en;
         camera_en_in    = vecs[i].cam_en;
         camera_pixel_in = vecs[i].cam;
         set_pos(vecs[i].h, vecs[i].v);
         pulse_nf();
         tick(); tick();
         check($sformatf("vec%0d", i), {8'h0, pixel_out}, {8'h0, vecs[i].exp_pix});
      end

      // Hit flash: lasts exactly 8 frames
      layer_en_in  = 4'b0000;
      camera_en_in = 1'b0;
      set_pos(11'd500, 10'd500);
      pulse_nf();
      hit_in = 1'b1;
      tick();
      hit_in = 1'b0;
      tick(); tick();
      check("flash_on", {8'h0, pixel_out}, 32'hFF0000);
      for (int k = 1; k <= 8; k++) begin
         pulse_nf();
         tick(); tick();
         check($sformatf("flash_nf%0d", k), {8'h0, pixel_out},
               (k < 8) ? 32'hFF0000 : 32'h0);
      end

      // Hit coincident with nf: load wins, full 8 frames
      hit_in = 1'b1;
      nf_in  = 1'b1;
      tick();
      hit_in = 1'b0;
      nf_in  = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         pulse_nf();
         tick(); tick();
         check($sformatf("flash_coinc_nf%0d", k), {8'h0, pixel_out},
               (k < 8) ? 32'hFF0000 : 32'h0);
      end

      // Both healths zero -> LOSE
      player_health_in   = 3'd0;
      opponent_health_in = 3'd0;
      nf_in = 1'b1;
      tick();
      nf_in = 1'b0;
      check("lose_mode", {30'h0, mode_out}, 32'd3);
      tick(); tick();
      check("lose_pixel", {8'h0, pixel_out}, 32'hFF0000);

      send_ir(32'h20DF_5BA4);
      check("lose_ignores_start", {30'h0, mode_out}, 32'd3);
      send_ir(32'h20DF_10EF);
      check("restart", {30'h0, mode_out}, 32'd0);

      player_health_in   = 3'd3;
      opponent_health_in = 3'd3;
      send_ir(32'h20DF_5AA5);
      check("enter_play_b", {30'h0, mode_out}, 32'd1);
      pulse_nf();
      check("play_stays", {30'h0, mode_out}, 32'd1);

      opponent_health_in = 3'd0;
      pulse_nf();
      check("win_mode", {30'h0, mode_out}, 32'd2);
      tick(); tick();
      check("win_pixel", {8'h0, pixel_out}, 32'h00FF00);

      // Asynchronous reset mid-line
      #3;
      rst_n_in = 1'b0;
      #1;
      check("async_rst_pixel", {8'h0, pixel_out}, 32'h0);
      check("async_rst_mode", {30'h0, mode_out}, 32'd0);
      tick();
      rst_n_in = 1'b1;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
